uart_prog_loader_ctrl: RTL

- Sequencer between the 32-bit UART word receiver and the instruction memory / CPU core.
- Consumes framed words (word + word_end level), decodes host commands and streams a counted program image into instruction memory.
- Controls CPU halt/run/reset around the download and detects stalled transfers.

---
 rtl/uart_prog_loader_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader_ctrl.sv
// Decodes host commands from framed UART words and streams a counted image into instruction memory.
// Latency: memory write issued 1 cycle after the word strobe; load_done rides on the final write.
// Backpressure: none; words are consumed on their rising word_end edge, stalls abort via timeout.
module uart_prog_loader_ctrl #(
    parameter int                ADDR_W         = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                TIMEOUT_CYCLES = 1000000,
    parameter int                CPU_RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       word_in,
    input  logic              word_end,
    input  logic              err_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              cpu_rst,
    output logic              busy,
    output logic              load_done,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(CPU_RST_CYCLES + 1);

    localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]     TO_ONE   = TW'(1);
    localparam logic [RW-1:0]     RST_LAST = RW'(CPU_RST_CYCLES - 1);
    localparam logic [RW-1:0]     RST_ONE  = RW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [32:0]       MAX_LEN  = 33'(1) << ADDR_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GET_LEN   = 2'd1,
        LOAD      = 2'd2,
        RST_PULSE = 2'd3
    } state_t;

    state_t            state;
    logic              word_end_q;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] addr;
    logic [TW-1:0]     tcnt;
    logic [RW-1:0]     rcnt;

    logic stb;
    logic timed_out;

    assign stb       = word_end & ~word_end_q;
    assign timed_out = (tcnt == TO_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            word_end_q <= 1'b0;
            cnt        <= '0;
            addr       <= '0;
            tcnt       <= '0;
            rcnt       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_run    <= 1'b0;
            cpu_rst    <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            word_end_q <= word_end;
            mem_we     <= 1'b0;
            load_done  <= 1'b0;
            // Clear first so any set later in this cycle takes priority.
            if (err_clr)
                err <= 1'b0;

            case (state)
                IDLE: begin
                    if (stb) begin
                        case (word_in[7:0])
                            8'h01: begin
                                cpu_run <= 1'b0;
                                tcnt    <= '0;
                                state   <= GET_LEN;
                            end
                            8'h02: cpu_run <= 1'b1;
                            8'h03: cpu_run <= 1'b0;
                            8'h04: begin
                                cpu_rst <= 1'b1;
                                rcnt    <= '0;
                                state   <= RST_PULSE;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end

                GET_LEN: begin
                    if (stb) begin
                        if (word_in == 32'd0) begin
                            load_done <= 1'b1;
                            state     <= IDLE;
                        end else if ({1'b0, word_in} > MAX_LEN) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt   <= word_in[ADDR_W:0];
                            addr  <= BASE_ADDR;
                            tcnt  <= '0;
                            state <= LOAD;
                        end
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TO_ONE;
                    end
                end

                LOAD: begin
                    if (stb) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= word_in;
                        addr      <= addr + ADDR_ONE;
                        cnt       <= cnt - CNT_ONE;
                        tcnt      <= '0;
                        if (cnt == CNT_ONE) begin
                            load_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TO_ONE;
                    end
                end

                RST_PULSE: begin
                    // Words arriving during the pulse are intentionally discarded.
                    if (rcnt == RST_LAST) begin
                        cpu_rst <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        rcnt <= rcnt + RST_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
